// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Handshake and control bundle between the multi-cycle RV32I
//               controller (master) and the shared datapath (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;

    logic        imem_req;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] instret;

    modport master (
        input  opcode, funct3, zero, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
               alu_op, mem_read, mem_write, reg_write, wb_sel, illegal,
               state, instret
    );

    modport slave (
        output opcode, funct3, zero, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
               alu_op, mem_read, mem_write, reg_write, wb_sel, illegal,
               state, instret
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Main sequencing FSM of the multi-cycle RV32I core; drives all
//               datapath enables/selects and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
    input  wire logic          clk,
    input  wire logic          rst,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        EXEC_LUI = 4'd4,
        ADDR     = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        WB_ALU   = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JAL      = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [2:0] c_F3_BEQ = 3'b000;
    localparam logic [2:0] c_F3_BNE = 3'b001;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instret;
    logic        r_illegal;

    logic        w_br_legal;
    logic        w_br_taken;
    logic        w_retire;

    logic        w_imem_req;
    logic        w_ir_write;
    logic        w_pc_write;
    logic        w_pc_src;
    logic [1:0]  w_alu_src_a;
    logic [1:0]  w_alu_src_b;
    logic [1:0]  w_alu_op;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_reg_write;
    logic [1:0]  w_wb_sel;

    assign w_br_legal = (bus.funct3 == c_F3_BEQ) || (bus.funct3 == c_F3_BNE);
    assign w_br_taken = ((bus.funct3 == c_F3_BEQ) &&  bus.zero) ||
                        ((bus.funct3 == c_F3_BNE) && !bus.zero);

    assign w_retire = (r_state == WB_ALU) || (r_state == WB_MEM) ||
                      (r_state == JAL) ||
                      ((r_state == MEM_WR) && bus.dmem_ready) ||
                      ((r_state == BRANCH) && w_br_legal);

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:    if (bus.imem_ready) w_next = DECODE;
            DECODE: begin
                case (bus.opcode)
                    c_OP_REG:               w_next = EXEC_R;
                    c_OP_IMM:               w_next = EXEC_I;
                    c_OP_LUI:               w_next = EXEC_LUI;
                    c_OP_LOAD, c_OP_STORE:  w_next = ADDR;
                    c_OP_BRANCH:            w_next = BRANCH;
                    c_OP_JAL:               w_next = JAL;
                    default:                w_next = TRAP;
                endcase
            end
            EXEC_R, EXEC_I, EXEC_LUI: w_next = WB_ALU;
            ADDR:     w_next = (bus.opcode == c_OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD:   if (bus.dmem_ready) w_next = WB_MEM;
            MEM_WR:   if (bus.dmem_ready) w_next = FETCH;
            WB_ALU, WB_MEM, JAL: w_next = FETCH;
            BRANCH:   w_next = w_br_legal ? FETCH : TRAP;
            TRAP:     w_next = TRAP;
            default:  w_next = TRAP;
        endcase
    end

    // The trap flag latches on the edge that enters TRAP and only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= FETCH;
            r_instret <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
            if (w_next == TRAP) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_imem_req  = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = 1'b0;
        w_alu_src_a = 2'b00;
        w_alu_src_b = 2'b00;
        w_alu_op    = 2'b00;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_wb_sel    = 2'b00;
        case (r_state)
            FETCH: begin
                w_imem_req  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = bus.imem_ready;
                w_pc_write  = bus.imem_ready;
            end
            DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
            end
            EXEC_R: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b10;
            end
            EXEC_I: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b10;
                w_alu_op    = 2'b10;
            end
            EXEC_LUI: begin
                w_alu_src_a = 2'b11;
                w_alu_src_b = 2'b10;
            end
            ADDR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b10;
            end
            MEM_RD:   w_mem_read  = 1'b1;
            MEM_WR:   w_mem_write = 1'b1;
            WB_ALU:   w_reg_write = 1'b1;
            WB_MEM: begin
                w_reg_write = 1'b1;
                w_wb_sel    = 2'b01;
            end
            BRANCH: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b01;
                w_pc_src    = 1'b1;
                w_pc_write  = w_br_taken;
            end
            JAL: begin
                w_pc_write  = 1'b1;
                w_pc_src    = 1'b1;
                w_reg_write = 1'b1;
                w_wb_sel    = 2'b10;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset directly so an in-flight access drops without waiting for an edge.
    assign bus.imem_req  = w_imem_req  & ~rst;
    assign bus.ir_write  = w_ir_write  & ~rst;
    assign bus.pc_write  = w_pc_write  & ~rst;
    assign bus.mem_read  = w_mem_read  & ~rst;
    assign bus.mem_write = w_mem_write & ~rst;
    assign bus.reg_write = w_reg_write & ~rst;

    assign bus.pc_src    = w_pc_src;
    assign bus.alu_src_a = w_alu_src_a;
    assign bus.alu_src_b = w_alu_src_b;
    assign bus.alu_op    = w_alu_op;
    assign bus.wb_sel    = w_wb_sel;
    assign bus.illegal   = r_illegal;
    assign bus.state     = r_state;
    assign bus.instret   = r_instret;

endmodule
`default_nettype wire
